// File: rtl/ext_bus_ctrl_if.sv
// Bundle of requester-side handshake signals and pin-level bus signals for ext_bus_ctrl.
// Handshake: REQn plus WEn/BEn/ADDRn/WDATAn stay stable until a one-cycle ACKn; RDATA is valid with ACKn.
interface ext_bus_ctrl_if;
  logic        REQ0;
  logic        WE0;
  logic [1:0]  BE0;
  logic [15:0] ADDR0;
  logic [15:0] WDATA0;
  logic        ACK0;
  logic        REQ1;
  logic        WE1;
  logic [1:0]  BE1;
  logic [15:0] ADDR1;
  logic [15:0] WDATA1;
  logic        ACK1;
  logic [15:0] RDATA;
  logic [1:0]  GNT;
  logic        BUSY;
  logic [15:0] BUS_ADDR;
  logic [15:0] BUS_DOUT;
  logic        BUS_DOE;
  logic [15:0] BUS_DIN;
  logic        BUS_RDN;
  logic        BUS_WR0N;
  logic        BUS_WR1N;

  modport slave (
    input  REQ0, WE0, BE0, ADDR0, WDATA0, REQ1, WE1, BE1, ADDR1, WDATA1, BUS_DIN,
    output ACK0, ACK1, RDATA, GNT, BUSY,
    output BUS_ADDR, BUS_DOUT, BUS_DOE, BUS_RDN, BUS_WR0N, BUS_WR1N
  );

  modport master (
    output REQ0, WE0, BE0, ADDR0, WDATA0, REQ1, WE1, BE1, ADDR1, WDATA1, BUS_DIN,
    input  ACK0, ACK1, RDATA, GNT, BUSY,
    input  BUS_ADDR, BUS_DOUT, BUS_DOE, BUS_RDN, BUS_WR0N, BUS_WR1N
  );
endinterface

// File: rtl/ext_bus_ctrl.sv
// Two-port round-robin sequencer for 16-bit cycles on the external asynchronous bus,
// with programmable setup / strobe / hold timing. Every output comes straight from a flop.
module ext_bus_ctrl #(
  parameter int SETUP_CYCLES = 1,
  parameter int WAIT_STATES  = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic         CLK,
  input  logic         RESETN,
  ext_bus_ctrl_if.slave bus,
  output logic [2:0]   DBG_STATE
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] WAIT_LD  = 8'(WAIT_STATES);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] rdata_q, rdata_d;
  logic        doe_q, doe_d;
  logic        rdn_q, rdn_d;
  logic        wr0n_q, wr0n_d;
  logic        wr1n_q, wr1n_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        busy_q, busy_d;
  logic        win;

  // Under contention the port that did not win last time goes next.
  assign win = (bus.REQ0 && bus.REQ1) ? ~last_q : bus.REQ1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    doe_d   = doe_q;
    rdn_d   = rdn_q;
    wr0n_d  = wr0n_q;
    wr1n_d  = wr1n_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          last_d  = win;
          we_d    = win ? bus.WE1 : bus.WE0;
          be_d    = win ? bus.BE1 : bus.BE0;
          addr_d  = win ? bus.ADDR1 : bus.ADDR0;
          if (we_d) dout_d = win ? bus.WDATA1 : bus.WDATA0;
          doe_d   = we_d;
          gnt_d   = win ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          // A write with no byte enables runs full timing but drops no strobe.
          rdn_d   = we_q;
          wr0n_d  = ~(we_q & be_q[0]);
          wr1n_d  = ~(we_q & be_q[1]);
          cnt_d   = WAIT_LD;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 8'd0) begin
          if (!we_q) rdata_d = bus.BUS_DIN;
          rdn_d   = 1'b1;
          wr0n_d  = 1'b1;
          wr1n_d  = 1'b1;
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          ack0_d  = ~last_q;
          ack1_d  = last_q;
          doe_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      be_q    <= 2'b00;
      addr_q  <= 16'h0000;
      dout_q  <= 16'h0000;
      rdata_q <= 16'h0000;
      doe_q   <= 1'b0;
      rdn_q   <= 1'b1;
      wr0n_q  <= 1'b1;
      wr1n_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      doe_q   <= doe_d;
      rdn_q   <= rdn_d;
      wr0n_q  <= wr0n_d;
      wr1n_q  <= wr1n_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.ACK0     = ack0_q;
  assign bus.ACK1     = ack1_q;
  assign bus.RDATA    = rdata_q;
  assign bus.GNT      = gnt_q;
  assign bus.BUSY     = busy_q;
  assign bus.BUS_ADDR = addr_q;
  assign bus.BUS_DOUT = dout_q;
  assign bus.BUS_DOE  = doe_q;
  assign bus.BUS_RDN  = rdn_q;
  assign bus.BUS_WR0N = wr0n_q;
  assign bus.BUS_WR1N = wr1n_q;
  assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Randomized bench for ext_bus_ctrl: a transaction-level model predicts grant order, per-cycle
// strobe/DOE/ACK windows from the timing parameters, and read data; two instances cover two timings.
module tb_ext_bus_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  // ---------------- stimulus state ----------------
  logic [1:0]  req;
  logic [1:0]  we_f;
  logic [1:0]  be_f [2];
  logic [15:0] addr_f [2];
  logic [15:0] wdata_f [2];
  logic [15:0] din;
  logic        sel;
  int          ps, pw, ph;
  logic [2:0]  dbg_a, dbg_b;

  ext_bus_ctrl_if ifa ();
  ext_bus_ctrl_if ifb ();

  always_comb begin
    ifa.REQ0 = req[0];  ifa.WE0 = we_f[0];  ifa.BE0 = be_f[0];  ifa.ADDR0 = addr_f[0];  ifa.WDATA0 = wdata_f[0];
    ifa.REQ1 = req[1];  ifa.WE1 = we_f[1];  ifa.BE1 = be_f[1];  ifa.ADDR1 = addr_f[1];  ifa.WDATA1 = wdata_f[1];
    ifa.BUS_DIN = din;
    ifb.REQ0 = req[0];  ifb.WE0 = we_f[0];  ifb.BE0 = be_f[0];  ifb.ADDR0 = addr_f[0];  ifb.WDATA0 = wdata_f[0];
    ifb.REQ1 = req[1];  ifb.WE1 = we_f[1];  ifb.BE1 = be_f[1];  ifb.ADDR1 = addr_f[1];  ifb.WDATA1 = wdata_f[1];
    ifb.BUS_DIN = din;
  end

  ext_bus_ctrl dut_a (.CLK(clk), .RESETN(resetn), .bus(ifa), .DBG_STATE(dbg_a));
  ext_bus_ctrl #(.SETUP_CYCLES(3), .WAIT_STATES(0), .HOLD_CYCLES(2))
    dut_b (.CLK(clk), .RESETN(resetn), .bus(ifb), .DBG_STATE(dbg_b));

  // Observed view of whichever instance is under test.
  logic [1:0]  m_gnt;
  logic        m_busy, m_ack0, m_ack1, m_doe, m_rdn, m_wr0n, m_wr1n;
  logic [15:0] m_rdata, m_addr, m_dout;
  always_comb begin
    m_gnt   = sel ? ifb.GNT      : ifa.GNT;
    m_busy  = sel ? ifb.BUSY     : ifa.BUSY;
    m_ack0  = sel ? ifb.ACK0     : ifa.ACK0;
    m_ack1  = sel ? ifb.ACK1     : ifa.ACK1;
    m_doe   = sel ? ifb.BUS_DOE  : ifa.BUS_DOE;
    m_rdn   = sel ? ifb.BUS_RDN  : ifa.BUS_RDN;
    m_wr0n  = sel ? ifb.BUS_WR0N : ifa.BUS_WR0N;
    m_wr1n  = sel ? ifb.BUS_WR1N : ifa.BUS_WR1N;
    m_rdata = sel ? ifb.RDATA    : ifa.RDATA;
    m_addr  = sel ? ifb.BUS_ADDR : ifa.BUS_ADDR;
    m_dout  = sel ? ifb.BUS_DOUT : ifa.BUS_DOUT;
  end

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  int          last_port;
  logic [15:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int pick(input logic r0, input logic r1);
    if (r0 && r1) return 1 - last_port;
    return r1 ? 1 : 0;
  endfunction

  function automatic void model_reset();
    last_port = 1;
    last_rd   = 16'h0000;
    exp_q.delete();
  endfunction

  // Record the outcome the model expects once port p's current request completes.
  function automatic void model_txn(input int p);
    exp_q.push_back(we_f[p] ? last_rd : din);
    if (!we_f[p]) last_rd = din;
    last_port = p;
  endfunction

  // Follow one transaction from grant to the following IDLE cycle, checking every cycle.
  task automatic watch_txn(input int port, input bit immediate);
    int          wait_n;
    int          ack_n;
    bit          in_win;
    logic        we;
    logic [1:0]  be;
    logic [15:0] addr, wdata, exp_rd;
    we = we_f[port]; be = be_f[port]; addr = addr_f[port]; wdata = wdata_f[port];
    exp_rd = exp_q.pop_front();
    ack_n  = ps + pw + ph + 2;
    wait_n = 0;
    @(negedge clk);
    while (m_gnt == 2'b00 && !immediate && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check("grant", m_gnt, port ? 2 : 1);
    if (m_gnt == 2'b00) return;
    for (int n = 1; n <= ack_n; n++) begin
      if (n > 1) @(negedge clk);
      in_win = (n >= ps + 1) && (n <= ps + pw + 1);
      check("strobes", {m_rdn, m_wr1n, m_wr0n},
            {!(in_win && !we), !(in_win && we && be[1]), !(in_win && we && be[0])});
      check("doe", m_doe, we && (n < ack_n));
      check("addr", m_addr, addr);
      if (we) check("dout", m_dout, wdata);
      check("gnt_busy", {m_gnt, m_busy}, {(port ? 2'b10 : 2'b01), 1'b1});
      check("ack", {m_ack1, m_ack0}, (n == ack_n) ? (port ? 2 : 1) : 0);
    end
    check("rdata", m_rdata, exp_rd);
    @(negedge clk);
    check("idle", {m_gnt, m_busy, m_ack1, m_ack0}, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input logic we, input logic [1:0] be,
                          input logic [15:0] addr, input logic [15:0] wdata);
    we_f[p] = we; be_f[p] = be; addr_f[p] = addr; wdata_f[p] = wdata;
  endtask

  task automatic rand_port(input int p);
    set_port(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             16'($urandom), 16'($urandom));
  endtask

  task automatic single(input int p, input logic [15:0] d);
    din = d;
    req[p] = 1'b1;
    model_txn(pick(p == 0, p == 1));
    watch_txn(p, 1'b1);
    req[p] = 1'b0;
  endtask

  task automatic set_timing(input bit s);
    req = 2'b00;
    resetn = 1'b0;
    sel = s;
    ps = s ? 3 : 1; pw = s ? 0 : 2; ph = s ? 2 : 1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int p;
    sel = 1'b0; ps = 1; pw = 2; ph = 1;
    req = 2'b00; din = 16'h0000;
    for (int i = 0; i < 2; i++) set_port(i, 1'b0, 2'b11, 16'h0000, 16'h0000);
    model_reset();

    // Reset held with REQ0 pending: bus quiet, no grant, no ACK.
    resetn = 1'b0;
    set_port(0, 1'b0, 2'b11, 16'h0F0F, 16'h0000);
    req[0] = 1'b1;
    din = 16'h5AA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_outputs", {m_rdn, m_wr1n, m_wr0n, m_doe, m_gnt, m_ack1, m_ack0, m_busy}, 9'b111_0_00_00_0);
      check("rst_regs", {m_addr, m_dout, m_rdata}, 0);
    end
    resetn = 1'b1;
    model_txn(pick(1'b1, 1'b0));
    watch_txn(0, 1'b1);
    req[0] = 1'b0;

    // Directed CPU read and byte-lane writes.
    set_port(0, 1'b0, 2'b11, 16'h1234, 16'h0000);
    single(0, 16'hBEEF);
    set_port(0, 1'b1, 2'b01, 16'h2000, 16'hA55A); single(0, 16'h0000);
    set_port(0, 1'b1, 2'b10, 16'h2002, 16'hA55A); single(0, 16'h0000);
    set_port(0, 1'b1, 2'b11, 16'h2004, 16'hA55A); single(0, 16'h0000);
    set_port(0, 1'b1, 2'b00, 16'h2006, 16'hA55A); single(0, 16'h0000);

    // Random single-requester traffic on either port.
    for (int i = 0; i < 12; i++) begin
      p = int'($urandom_range(0, 1));
      rand_port(p);
      single(p, 16'($urandom));
    end

    // Both ports held high: strict alternation with one IDLE cycle between.
    rand_port(0); rand_port(1);
    din = 16'($urandom);
    req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      p = pick(1'b1, 1'b1);
      model_txn(p);
      watch_txn(p, 1'b1);
      rand_port(p);
      din = 16'($urandom);
    end
    req = 2'b00;
    @(negedge clk);

    // Reset during the strobe of a debug-port write, then re-served.
    set_port(1, 1'b1, 2'b11, 16'h4444, 16'h1357);
    req[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_strobe_low", {m_wr1n, m_wr0n, m_doe}, 3'b001);
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst", {m_rdn, m_wr1n, m_wr0n, m_doe, m_gnt, m_ack1, m_ack0}, 8'b111_0_00_00);
    @(negedge clk);
    check("mid_rst_noack", {m_ack1, m_ack0, m_busy}, 0);
    resetn = 1'b1;
    model_reset();
    din = 16'h0000;
    model_txn(pick(1'b0, 1'b1));
    watch_txn(1, 1'b1);
    req[1] = 1'b0;

    // Alternate timing: 3 setup, 1 strobe, 2 hold.
    set_timing(1'b1);
    set_port(0, 1'b0, 2'b11, 16'h0ABC, 16'h0000);
    single(0, 16'hC0DE);
    set_port(1, 1'b1, 2'b01, 16'h0ABE, 16'h7E7E);
    single(1, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      p = int'($urandom_range(0, 1));
      rand_port(p);
      single(p, 16'($urandom));
    end
    rand_port(0); rand_port(1);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      p = pick(1'b1, 1'b1);
      model_txn(p);
      watch_txn(p, 1'b1);
      rand_port(p);
    end
    req = 2'b00;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ext_bus_ctrl.md
Name: ext_bus_ctrl

Overview:
Sequences 16-bit read/write cycles on the dev board's external asynchronous bus (address, bidirectional data, RDN and per-byte WR0N/WR1N strobes). Two requesters share the bus: the CPU (port 0) and the debug/loader port (port 1). Arbitration is round-robin. Setup, strobe and hold timing are programmable so slow SRAM and peripherals meet their timing. The block sits between the core bus fabric and the pin-level I/O; the top level maps BUS_* to PIN_* and builds the PIN_DBUS tristate from BUS_DOUT/BUS_DOE.

Parameters:
SETUP_CYCLES, 1, cycles address/data are valid before the strobe falls (range 1..255)
WAIT_STATES, 2, extra strobe-low cycles; strobe is low for WAIT_STATES+1 cycles (range 0..254)
HOLD_CYCLES, 1, cycles address/data are held after the strobe rises (range 1..255)

Ports:
CLK  input  1  system clock
RESETN  input  1  synchronous reset, active low
REQ0  input  1  CPU request; held high with WE0/BE0/ADDR0/WDATA0 stable until ACK0
WE0  input  1  CPU: 1 = write, 0 = read
BE0  input  2  CPU byte enables; bit0 = D[7:0], bit1 = D[15:8]
ADDR0  input  16  CPU address
WDATA0  input  16  CPU write data
ACK0  output  1  one-cycle completion pulse to the CPU
REQ1, WE1, BE1, ADDR1, WDATA1  input  1/1/2/16/16  debug port; same meaning as port 0
ACK1  output  1  one-cycle completion pulse to the debug port
RDATA  output  16  read data; valid when ACKn is high; held until the next read completes
GNT  output  2  one-hot current owner; 00 when idle
BUSY  output  1  high in every state except IDLE
BUS_ADDR  output  16  external address
BUS_DOUT  output  16  external write data
BUS_DOE  output  1  data output enable, high = drive
BUS_DIN  input  16  external read data
BUS_RDN  output  1  read strobe, active low
BUS_WR0N  output  1  low-byte write strobe, active low
BUS_WR1N  output  1  high-byte write strobe, active low

Behaviour:
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset (RESETN low at a CLK edge):
  - state = IDLE; RDN, WR0N and WR1N = 1; BUS_DOE = 0; BUS_ADDR, BUS_DOUT, RDATA = 0.
  - ACK0, ACK1 = 0; GNT = 00; BUSY = 0; LAST = 1, so port 0 wins the first contention.
- Reset mid-transaction: strobes go high and DOE goes low at that edge. No ACK is issued. The requester must re-request.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE. An 8-bit counter CNT times SETUP, STROBE and HOLD.
- IDLE:
  - Only one request present: grant it.
  - Both present: grant the port other than LAST.
  - Neither present: stay in IDLE.
  - On grant: latch WE/BE/ADDR/WDATA of the winner, set GNT, set LAST = winner, set BUSY, go to SETUP with CNT = SETUP_CYCLES-1.
- SETUP: BUS_ADDR is driven. For writes, BUS_DOUT is driven and BUS_DOE = 1. When CNT = 0, go to STROBE with CNT = WAIT_STATES.
- STROBE:
  - Read: RDN = 0.
  - Write: WR0N = ~BE[0] and WR1N = ~BE[1].
  - BE = 00 write: no strobe falls, but timing and ACK are unchanged (null cycle).
  - When CNT = 0: capture BUS_DIN into RDATA (reads only), raise all strobes at that edge, go to HOLD with CNT = HOLD_CYCLES-1.
- HOLD: strobes high. Address, data and DOE are unchanged. When CNT = 0, go to DONE.
- DONE:
  - ACKn = 1 for the granted port, for exactly one cycle.
  - BUS_DOE = 0. BUS_ADDR keeps its last value.
  - Next state is IDLE unconditionally; then GNT = 00 and BUSY = 0.
  - The requester samples ACK and drops or changes REQ before IDLE samples it, so back-to-back transactions cost one IDLE cycle.
- Requests arriving while BUSY wait; they are never lost or reordered.
- Round-robin guarantees each of two continuously requesting ports gets alternate transactions.
- Latency with defaults:
  - Grant edge to first strobe-low cycle: 1 cycle.
  - Strobe low for 3 cycles.
  - ACK in the 6th cycle after the grant edge.
  - Request-to-ACK = SETUP_CYCLES + WAIT_STATES + HOLD_CYCLES + 3 cycles, including the IDLE sample.
- Reads never assert DOE. RDN, WR0N and WR1N are never low simultaneously.

Test Plan:
- Reset: hold RESETN low 3 cycles while REQ0 = 1 -> all strobes 1, DOE 0, GNT 00, no ACK. Release -> port 0 is granted on the first IDLE edge.
- CPU read: ADDR0 = 16'h1234, BUS_DIN = 16'hBEEF (defaults) -> RDN low exactly 3 cycles, BUS_ADDR = 1234 from SETUP through DONE, ACK0 one cycle with RDATA = BEEF, DOE never high.
- Byte writes: WE0 = 1 with BE0 = 01, then 10, then 11, WDATA0 = 16'hA55A -> WR0N only, WR1N only, then both, each low 3 cycles. DOE high SETUP..HOLD, BUS_DOUT = A55A. BE0 = 00 -> no strobe, ACK0 still after 6 cycles.
- Contention: REQ0 and REQ1 held high continuously for 4 transactions -> grant order 0,1,0,1. GNT is one-hot; ACK0 and ACK1 alternate and are never coincident. One IDLE cycle between transactions.
- Timing parameters: SETUP_CYCLES = 3, WAIT_STATES = 0, HOLD_CYCLES = 2 -> strobe low 1 cycle, 3 setup cycles before it, 2 hold cycles after it, ACK at cycle 7 after grant.
- Mid-cycle reset: assert RESETN low during STROBE of a write -> WRxN high and DOE 0 at that edge, no ACK. After release, a pending REQ1 is served normally.
